door_ctrl: RTL and testbench



---
 rtl/door_pkg.sv | 19 +
 rtl/door_timer.sv | 30 +++
 rtl/door_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_door_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared types and constants for the elevator door controller.
package door_pkg;

    // Door sequencing states; the state register holds one of these.
    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } door_state_t;

    // Floors 0,1,3,5 open both sides; floors 2,4,6 open the front only.
    localparam logic [13:0] DOOR_SIDE_MASK_DEFAULT = 14'b01_11_01_11_01_11_11;

    // Bit positions of the door sides inside a per-floor mask.
    localparam int SIDE_FRONT = 0;
    localparam int SIDE_REAR  = 1;

endpackage

// File: rtl/door_timer.sv
// Loadable down counter that times the door phases. Expiry is flagged while
// the count is 1, i.e. on the last cycle of a phase; the count never wraps.
module door_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    // Count register: load has priority, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/door_ctrl.sv
// Elevator door controller: timed open/dwell/close sequence per car with
// per-floor side selection. Optional feature macro DOOR_NUDGE_EN adds a
// reopen counter that forces the doors shut after MAX_REOPENS obstructions.
module door_ctrl
    import door_pkg::*;
#(
    parameter int N_FLOORS     = 7,
    parameter int N_SIDES      = 2,
    parameter logic [N_FLOORS*N_SIDES-1:0] SIDE_MASK = DOOR_SIDE_MASK_DEFAULT,
    parameter int OPEN_CYCLES  = 4,
    parameter int DWELL_CYCLES = 16,
    parameter int CLOSE_CYCLES = 4,
    parameter int MAX_REOPENS  = 3,
    parameter int FL_W         = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FL_W-1:0]    current_fl,
    input  logic               at_floor,
    input  logic               open_req,
    input  logic               close_req,
    input  logic               obstruct,
    output logic [N_SIDES-1:0] door_open,
    output logic               door_closed,
    output logic               req_ignored,
    output logic               fault,
    output logic               nudge
);

    localparam int T_MAX0 = (OPEN_CYCLES > DWELL_CYCLES) ? OPEN_CYCLES : DWELL_CYCLES;
    localparam int T_MAX  = (T_MAX0 > CLOSE_CYCLES) ? T_MAX0 : CLOSE_CYCLES;
    localparam int TW     = $clog2(T_MAX + 1);

    door_state_t        r_state, w_next_state;
    logic [N_SIDES-1:0] r_side_q, w_next_side, w_fl_mask;
    logic [N_SIDES-1:0] r_door_open;
    logic               r_door_closed, r_req_ignored, r_fault, r_nudge;
    logic               w_fl_valid, w_accept, w_ignore;
    logic               w_load, w_expired, w_nudge_lock;
    logic [TW-1:0]      w_load_val;

    door_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .value   (w_load_val),
        .expired (w_expired)
    );

    assign w_fl_valid = ({1'b0, current_fl} < (FL_W + 1)'(N_FLOORS));
    assign w_accept   = at_floor && w_fl_valid && (w_fl_mask != '0);

    // Look up the side mask of the current floor; invalid floors give zero.
    always_comb begin
        w_fl_mask = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if (current_fl == FL_W'(f)) begin
                w_fl_mask = SIDE_MASK[f*N_SIDES +: N_SIDES];
            end else begin
                w_fl_mask = w_fl_mask;
            end
        end
    end

    // Next-state, timer load and side latch decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_side  = r_side_q;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_ignore     = 1'b0;
        case (r_state)
            ST_CLOSED: begin
                if (open_req && w_accept) begin
                    w_next_state = ST_OPENING;
                    w_next_side  = w_fl_mask;
                    w_load       = 1'b1;
                    w_load_val   = TW'(OPEN_CYCLES);
                end else if (open_req) begin
                    w_ignore = 1'b1;
                end else begin
                    w_next_state = ST_CLOSED;
                end
            end
            ST_OPENING: begin
                // open_req is deliberately not looked at while opening
                if (w_expired) begin
                    w_next_state = ST_OPEN;
                    w_load       = 1'b1;
                    w_load_val   = TW'(DWELL_CYCLES);
                end else begin
                    w_next_state = ST_OPENING;
                end
            end
            ST_OPEN: begin
                if (obstruct || open_req) begin
                    w_load     = 1'b1;
                    w_load_val = TW'(DWELL_CYCLES);
                end else if (close_req || w_expired) begin
                    w_next_state = ST_CLOSING;
                    w_load       = 1'b1;
                    w_load_val   = TW'(CLOSE_CYCLES);
                end else begin
                    w_next_state = ST_OPEN;
                end
            end
            ST_CLOSING: begin
                if ((obstruct && !w_nudge_lock) || open_req) begin
                    w_next_state = ST_OPENING;
                    w_load       = 1'b1;
                    w_load_val   = TW'(OPEN_CYCLES);
                end else if (w_expired) begin
                    w_next_state = ST_CLOSED;
                end else begin
                    w_next_state = ST_CLOSING;
                end
            end
            default: begin
                w_next_state = ST_CLOSED;
            end
        endcase
    end

    // State and latched side mask.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_CLOSED;
            r_side_q <= '0;
        end else begin
            r_state  <= w_next_state;
            r_side_q <= w_next_side;
        end
    end

    // Registered Moore outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_door_open   <= '0;
            r_door_closed <= 1'b1;
            r_req_ignored <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_door_open   <= (w_next_state == ST_CLOSED) ? '0 : w_next_side;
            r_door_closed <= (w_next_state == ST_CLOSED);
            r_req_ignored <= w_ignore;
            r_fault       <= r_fault | (!at_floor && (r_state != ST_CLOSED));
        end
    end

`ifdef DOOR_NUDGE_EN
    localparam int RC_W = (MAX_REOPENS > 0) ? $clog2(MAX_REOPENS + 1) : 1;

    logic [RC_W-1:0] r_reopen_cnt, w_reopen_cnt_nxt;
    logic            w_reopen_obs;

    assign w_nudge_lock = (r_reopen_cnt >= RC_W'(MAX_REOPENS));
    assign w_reopen_obs = (r_state == ST_CLOSING) && obstruct && !w_nudge_lock;

    // Reopen count: bump on obstruction reopens, clear when the doors close.
    always_comb begin
        w_reopen_cnt_nxt = r_reopen_cnt;
        if (w_next_state == ST_CLOSED) begin
            w_reopen_cnt_nxt = '0;
        end else if (w_reopen_obs) begin
            w_reopen_cnt_nxt = r_reopen_cnt + RC_W'(1);
        end else begin
            w_reopen_cnt_nxt = r_reopen_cnt;
        end
    end

    // Reopen counter and nudge flag, held until the doors are closed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_reopen_cnt <= '0;
            r_nudge      <= 1'b0;
        end else begin
            r_reopen_cnt <= w_reopen_cnt_nxt;
            r_nudge      <= (w_next_state != ST_CLOSED) &&
                            (w_reopen_cnt_nxt >= RC_W'(MAX_REOPENS));
        end
    end
`else
    assign w_nudge_lock = 1'b0;

    // Without the nudge feature the flag stays low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_nudge <= 1'b0;
        end else begin
            r_nudge <= 1'b0;
        end
    end
`endif

    assign door_open   = r_door_open;
    assign door_closed = r_door_closed;
    assign req_ignored = r_req_ignored;
    assign fault       = r_fault;
    assign nudge       = r_nudge;

endmodule

// File: tb/tb_door_ctrl.sv
// Directed, scoreboard-based bench for door_ctrl (default parameters).
module tb_door_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] current_fl;
    logic       at_floor, open_req, close_req, obstruct;
    logic [1:0] door_open;
    logic       door_closed, req_ignored, fault, nudge;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] dopen;
        logic       dclosed;
        logic       rign;
        logic       flt;
        logic       ndg;
    } exp_t;

    exp_t sb[$];

    door_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .current_fl  (current_fl),
        .at_floor    (at_floor),
        .open_req    (open_req),
        .close_req   (close_req),
        .obstruct    (obstruct),
        .door_open   (door_open),
        .door_closed (door_closed),
        .req_ignored (req_ignored),
        .fault       (fault),
        .nudge       (nudge)
    );

    always #5 clk = ~clk;

    // Push the expectation for the coming edge, advance one clock, then pop and compare.
    task automatic cyc(input string tag, input logic [1:0] dopen, input logic dclosed,
                       input logic rign, input logic flt, input logic ndg);
        exp_t e;
        exp_t g;
        e.tag = tag; e.dopen = dopen; e.dclosed = dclosed;
        e.rign = rign; e.flt = flt; e.ndg = ndg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checks++;
        assert (door_open === g.dopen) else begin
            errors++;
            $error("FAIL %s door_open got %b expected %b", g.tag, door_open, g.dopen);
        end
        checks++;
        assert (door_closed === g.dclosed) else begin
            errors++;
            $error("FAIL %s door_closed got %b expected %b", g.tag, door_closed, g.dclosed);
        end
        checks++;
        assert (req_ignored === g.rign) else begin
            errors++;
            $error("FAIL %s req_ignored got %b expected %b", g.tag, req_ignored, g.rign);
        end
        checks++;
        assert (fault === g.flt) else begin
            errors++;
            $error("FAIL %s fault got %b expected %b", g.tag, fault, g.flt);
        end
        checks++;
        assert (nudge === g.ndg) else begin
            errors++;
            $error("FAIL %s nudge got %b expected %b", g.tag, nudge, g.ndg);
        end
    endtask

    initial begin
        logic ng;
        ng = 1'b0;
        reset_n = 1'b0; current_fl = 3'd0; at_floor = 1'b1;
        open_req = 1'b0; close_req = 1'b0; obstruct = 1'b0;
        #2;
        cyc("reset0", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("reset1", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc("idle", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Floor 1, both sides, full 4+16+4 sequence; floor change while open is ignored.
        current_fl = 3'd1; open_req = 1'b1;
        cyc("fl1_accept", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i == 5) current_fl = 3'd2;
            cyc("fl1_seq", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc("fl1_closed", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Floor 2, front only; open_req during OPENING has no effect.
        open_req = 1'b1;
        cyc("fl2_accept", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b0;
        cyc("fl2_opening", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b1;
        cyc("fl2_opening_req", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b0;
        cyc("fl2_opening", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("fl2_open", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        // close_req on the third OPEN cycle: CLOSING for 4 cycles
        close_req = 1'b1;
        cyc("fl2_close_req", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        close_req = 1'b0;
        cyc("fl2_closing", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        // obstruct mid-CLOSING: full reopen, another 24 cycles before closed
        obstruct = 1'b1;
        cyc("fl2_reopen", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        obstruct = 1'b0;
        for (int i = 0; i < 23; i++) cyc("fl2_reopen_seq", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("fl2_closed", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rejected requests: invalid floor, then not level at a valid floor.
        current_fl = 3'd7; open_req = 1'b1;
        cyc("fl7_ignored", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        open_req = 1'b0;
        cyc("fl7_pulse_end", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        current_fl = 3'd1; at_floor = 1'b0; open_req = 1'b1;
        cyc("not_level_ignored", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        at_floor = 1'b1; open_req = 1'b0;
        cyc("not_level_end", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Repeated obstruction reopens at floor 0.
        current_fl = 3'd0; open_req = 1'b1;
        cyc("ob_accept", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            for (int i = 0; i < 20; i++) cyc("ob_seq", 2'b11, 1'b0, 1'b0, 1'b0, ng);
            obstruct = 1'b1;
`ifdef DOOR_NUDGE_EN
            if (r == 4) begin
                cyc("ob_ignored", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
                obstruct = 1'b0;
                cyc("nudge_closing", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
                cyc("nudge_closing", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
                cyc("nudge_closed", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                if (r == 3) ng = 1'b1;
                cyc("ob_reopen", 2'b11, 1'b0, 1'b0, 1'b0, ng);
                obstruct = 1'b0;
            end
`else
            cyc("ob_reopen", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            obstruct = 1'b0;
`endif
        end
`ifndef DOOR_NUDGE_EN
        for (int i = 0; i < 23; i++) cyc("ob4_seq", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ob4_closed", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Fault on leaving the floor while open, sticky, then cleared by reset.
        current_fl = 3'd1; open_req = 1'b1;
        cyc("flt_accept", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        open_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc("flt_seq", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        at_floor = 1'b0;
        cyc("flt_set", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        at_floor = 1'b1;
        cyc("flt_sticky", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("flt_sticky2", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b0; open_req = 1'b1; obstruct = 1'b1;
        cyc("mid_reset", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1; open_req = 1'b0; obstruct = 1'b0;
        cyc("post_reset", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
